// File: rtl/bpu_pkg.sv
// Shared BPU definitions: instruction width, opcode constants and the fetch
// sequencer state encoding.
package bpu_pkg;

  localparam int INST_W = 16;

  localparam logic [4:0] OP_NULL = 5'b00000;
  localparam logic [4:0] OP_JUMP = 5'b00101;
  localparam logic [4:0] OP_HALT = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  function automatic logic is_halt(input logic [INST_W-1:0] word);
    return word[INST_W-1:INST_W-5] == OP_HALT;
  endfunction

endpackage

// File: rtl/bpu_inst_fifo.sv
// Prefetch FIFO of {pc, inst} entries with synchronous flush and an occupancy
// count. The head is presented combinationally and reads as zero when empty.
module bpu_inst_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]             wr_ptr_reg;
  logic [PW-1:0]             rd_ptr_reg;
  logic [CW-1:0]             count_reg;
  logic [CW-1:0]             count_next;
  logic                      full;
  logic                      do_push;
  logic                      do_pop;
  logic [DEPTH-1:0][W-1:0]   entries;

  assign valid   = (count_reg != '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && valid;
  // Flush beats a simultaneous push; a full FIFO still accepts a push when popping.
  assign do_push = push && !flush && (!full || do_pop);
  assign count   = count_reg;
  assign head    = valid ? entries[rd_ptr_reg] : '0;

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [W-1:0] entry_reg;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        entry_reg <= '0;
      end else if (do_push && (wr_ptr_reg == PW'(gi))) begin
        entry_reg <= data;
      end
    end
    assign entries[gi] = entry_reg;
  end

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/bpu_inst_fetch.sv
// BPU instruction fetch sequencer: owns the PC, streams SRAM words into the
// prefetch FIFO and hands them to the decoder, honouring redirects and HALT.
module bpu_inst_fetch
  import bpu_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  output logic              isram_en,
  output logic [ADDR_W-1:0] isram_addr,
  input  logic [INST_W-1:0] isram_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_W + INST_W;

  fetch_state_t      state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic              inflight_reg;
  logic [ADDR_W-1:0] inflight_pc_reg;
  logic              busy_reg;
  logic              done_reg;

  logic [CW-1:0]     fifo_count;
  logic [EW-1:0]     fifo_head;
  logic              fifo_valid;
  logic [CW:0]       occupancy;
  logic              credit_ok;
  logic              start_take;
  logic              redir_take;
  logic              push;
  logic              halt_back;
  logic              issue;
  logic              pop;
  logic              halt_pop;

  assign start_take = start && (state_reg == ST_IDLE);
  assign redir_take = redir_valid && (state_reg != ST_IDLE);

  // A redirect kills the word returning this cycle simply by refusing its push;
  // no read is issued alongside a redirect, so nothing else can be in flight.
  assign push      = inflight_reg && !redir_take;
  assign halt_back = push && is_halt(isram_rdata);

  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_reg};
  assign credit_ok = occupancy < (CW+1)'(DEPTH);

  assign issue = (state_reg == ST_RUN) && !redir_take && !halt_back && credit_ok;

  assign pop      = fifo_valid && inst_ready;
  assign halt_pop = pop && (state_reg == ST_DRAIN) && is_halt(inst) && !redir_take;

  assign isram_en   = issue;
  assign isram_addr = pc_reg;
  assign inst_valid = fifo_valid;
  assign {inst_pc, inst} = fifo_head;
  assign busy = busy_reg;
  assign done = done_reg;

  bpu_inst_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redir_take || start_take),
    .push  (push),
    .data  ({inflight_pc_reg, isram_rdata}),
    .pop   (pop),
    .head  (fifo_head),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= ST_IDLE;
      pc_reg          <= '0;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      done_reg     <= 1'b0;
      inflight_reg <= issue;
      if (issue) inflight_pc_reg <= pc_reg;

      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_RUN;
            pc_reg    <= start_pc;
            busy_reg  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (redir_take) begin
            pc_reg <= redir_pc;
          end else begin
            if (issue)     pc_reg    <= pc_reg + ADDR_W'(1);
            if (halt_back) state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The buffered HALT was on a speculative path; a redirect resumes fetching.
          if (redir_take) begin
            pc_reg    <= redir_pc;
            state_reg <= ST_RUN;
          end else if (halt_pop) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bpu_inst_fetch.sv
// Self-checking bench for bpu_inst_fetch: SRAM model, expected-instruction
// scoreboard filled at start/redirect time and drained on each handshake.
module tb_bpu_inst_fetch;

  localparam int ADDR_W = 16;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_pc = '0;
  logic              isram_en;
  logic [ADDR_W-1:0] isram_addr;
  logic [15:0]       isram_rdata = '0;
  logic              inst_valid;
  logic [15:0]       inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready = 1'b0;
  logic              redir_valid = 1'b0;
  logic [ADDR_W-1:0] redir_pc = '0;
  logic              busy;
  logic              done;

  bpu_inst_fetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_pc    (start_pc),
    .isram_en    (isram_en),
    .isram_addr  (isram_addr),
    .isram_rdata (isram_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  logic [15:0] sram [0:65535];
  always @(posedge clk) if (isram_en) isram_rdata <= sram[isram_addr];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          bad_fetch = 0;
  logic [15:0] forbid_addr = '0;
  bit          forbid_en = 1'b0;
  logic [31:0] exp_q [$];
  int          dq [$];
  bit          prev_stall = 1'b0;
  logic [31:0] prev_head = '0;

  // Expected stream: walk memory from pc up to and including the first HALT.
  task automatic push_prog(input logic [15:0] pc0);
    logic [15:0] pc;
    pc = pc0;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back({pc, sram[pc]});
      if (sram[pc][15:11] == 5'b11111) break;
      pc = pc + 16'd1;
    end
  endtask

  task automatic cycle();
    logic [31:0] got;
    logic [31:0] e;
    #1;
    got = {inst_pc, inst};
    if (forbid_en && isram_en && isram_addr == forbid_addr) bad_fetch++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (prev_stall) begin
      checks++;
      if (!inst_valid || got !== prev_head) begin
        errors++;
        $display("FAIL hold_stable: cyc=%0d got valid=%0b %h, required valid=1 %h", cyc, inst_valid, got, prev_head);
      end
    end
    if (inst_valid && inst_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_inst: cyc=%0d got pc=%h inst=%h, required no transfer", cyc, inst_pc, inst);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL inst_xfer: cyc=%0d got pc=%h inst=%h, required pc=%h inst=%h", cyc, inst_pc, inst, e[31:16], e[15:0]);
        end
      end
      $display("xfer cyc=%0d pc=%h inst=%h", cyc, inst_pc, inst);
      dq.push_back(cyc);
    end
    prev_stall = inst_valid && !inst_ready && !redir_valid && rst;
    prev_head  = got;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until_done(input int budget, input string name);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s_timeout: no done after %0d cycles, required done", name, budget);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    logic [15:0] act [7];
    string       nm [7];
    act = '{16'(isram_en), isram_addr, 16'(inst_valid), inst, inst_pc, 16'(busy), 16'(done)};
    nm  = '{"isram_en", "isram_addr", "inst_valid", "inst", "inst_pc", "busy", "done"};
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (act[i] !== 16'h0) begin
        errors++;
        $display("FAIL %s_%s: got %h, required 0000", name, nm[i], act[i]);
      end
    end
  endtask

  task automatic start_prog(input logic [15:0] pc);
    exp_q.delete();
    dq.delete();
    push_prog(pc);
    bad_fetch = 0;
    prev_stall = 1'b0;
    cyc = 0;
    start_pc = pc;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_straight();
    forbid_addr = 16'h0014;
    forbid_en = 1'b1;
    inst_ready = 1'b1;
    start_prog(16'h0010);
    #1;
    checks++;
    if (busy !== 1'b1 || isram_en !== 1'b1 || isram_addr !== 16'h0010) begin
      errors++;
      $display("FAIL straight_first_read: got busy=%0b en=%0b addr=%h, required 1 1 0010", busy, isram_en, isram_addr);
    end
    run_until_done(20, "straight");
    checks++;
    if (dq.size() != 4) begin
      errors++;
      $display("FAIL straight_count: got %0d transfers, required 4", dq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (dq[i] != i + 3) begin
          errors++;
          $display("FAIL straight_timing: transfer %0d in cycle %0d, required %0d", i, dq[i], i + 3);
        end
      end
    end
    checks++;
    if (done_cyc != 7) begin
      errors++;
      $display("FAIL straight_done_cycle: got %0d, required 7", done_cyc);
    end
    checks++;
    if (bad_fetch != 0) begin
      errors++;
      $display("FAIL straight_past_halt: got %0d reads of 0014, required 0", bad_fetch);
    end
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL straight_busy_low: got %0b, required 0", busy);
    end
    begin
      int d0;
      d0 = done_cnt;
      repeat (3) cycle();
      checks++;
      if (done_cnt != d0) begin
        errors++;
        $display("FAIL straight_single_done: got %0d extra done pulses, required 0", done_cnt - d0);
      end
    end
  endtask

  task automatic test_backpressure();
    int d0;
    int n;
    forbid_addr = 16'h002A;
    forbid_en = 1'b1;
    inst_ready = 1'b1;
    d0 = done_cnt;
    start_prog(16'h0020);
    n = 0;
    while (done_cnt == d0 && n < 80) begin
      inst_ready = ((cyc % 3) != 2);
      cycle();
      n++;
    end
    inst_ready = 1'b1;
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL backpressure_timeout: no done after %0d cycles, required done", n);
    end
    checks++;
    if (dq.size() != 10 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL backpressure_count: got %0d transfers, %0d left, required 10 and 0", dq.size(), exp_q.size());
    end
    checks++;
    if (bad_fetch != 0) begin
      errors++;
      $display("FAIL backpressure_past_halt: got %0d reads of 002A, required 0", bad_fetch);
    end
    repeat (2) cycle();
  endtask

  task automatic test_redirect();
    int first;
    forbid_en = 1'b0;
    inst_ready = 1'b1;
    start_prog(16'h0010);
    while (cyc < 4) cycle();
    redir_pc = 16'h0010;
    redir_valid = 1'b1;
    cycle();
    redir_valid = 1'b0;
    exp_q.delete();
    push_prog(16'h0010);
    #1;
    checks++;
    if (inst_valid !== 1'b0 || isram_en !== 1'b1 || isram_addr !== 16'h0010) begin
      errors++;
      $display("FAIL redirect_next: got valid=%0b en=%0b addr=%h, required 0 1 0010", inst_valid, isram_en, isram_addr);
    end
    run_until_done(20, "redirect");
    first = -1;
    foreach (dq[i]) if (first < 0 && dq[i] > 4) first = dq[i];
    checks++;
    if (first != 7) begin
      errors++;
      $display("FAIL redirect_latency: first transfer after redirect in cycle %0d, required 7", first);
    end
    checks++;
    if (done_cyc != 11 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL redirect_replay: got done cycle %0d, %0d left, required 11 and 0", done_cyc, exp_q.size());
    end
    repeat (2) cycle();
  endtask

  task automatic test_redirect_drain();
    int d0;
    forbid_en = 1'b0;
    inst_ready = 1'b0;
    d0 = done_cnt;
    start_prog(16'h0010);
    while (cyc < 8) cycle();
    #1;
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 16'h0010 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drain_buffered: got valid=%0b pc=%h busy=%0b, required 1 0010 1", inst_valid, inst_pc, busy);
    end
    redir_pc = 16'h0010;
    redir_valid = 1'b1;
    cycle();
    redir_valid = 1'b0;
    exp_q.delete();
    push_prog(16'h0010);
    #1;
    checks++;
    if (inst_valid !== 1'b0 || isram_en !== 1'b1 || isram_addr !== 16'h0010 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drain_redirect: got valid=%0b en=%0b addr=%h busy=%0b, required 0 1 0010 1", inst_valid, isram_en, isram_addr, busy);
    end
    inst_ready = 1'b1;
    run_until_done(20, "drain");
    checks++;
    if (done_cnt != d0 + 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_replay: got %0d done pulses, %0d left, required 1 and 0", done_cnt - d0, exp_q.size());
    end
    repeat (2) cycle();
  endtask

  task automatic test_wrap();
    sram[16'hFFFF] = 16'h2345;
    sram[16'h0000] = 16'hF8AA;
    forbid_addr = 16'h0001;
    forbid_en = 1'b1;
    inst_ready = 1'b1;
    start_prog(16'hFFFF);
    run_until_done(20, "wrap");
    checks++;
    if (dq.size() != 2 || exp_q.size() != 0 || bad_fetch != 0) begin
      errors++;
      $display("FAIL wrap_stream: got %0d transfers, %0d left, %0d bad reads, required 2 0 0", dq.size(), exp_q.size(), bad_fetch);
    end
    repeat (2) cycle();
  endtask

  task automatic test_reset_mid();
    int d0;
    forbid_en = 1'b0;
    inst_ready = 1'b1;
    start_prog(16'h0020);
    repeat (4) cycle();
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    d0 = done_cnt;
    cycle();
    rst = 1'b1;
    repeat (5) cycle();
    checks++;
    if (done_cnt != d0 || busy !== 1'b0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_quiet: got done=%0d busy=%0b valid=%0b, required 0 0 0", done_cnt - d0, busy, inst_valid);
    end
    start_prog(16'h0010);
    run_until_done(20, "midreset_restart");
    checks++;
    if (dq.size() != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_restart: got %0d transfers, %0d left, required 4 and 0", dq.size(), exp_q.size());
    end
    repeat (2) cycle();
  endtask

  task automatic test_back_to_back();
    forbid_addr = 16'h0032;
    forbid_en = 1'b1;
    inst_ready = 1'b1;
    start_prog(16'h0010);
    while (cyc < 7) cycle();
    push_prog(16'h0030);
    start_pc = 16'h0030;
    start = 1'b1;
    #1;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: got %0b in cycle 7, required 1", done);
    end
    cycle();
    start = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || isram_en !== 1'b1 || isram_addr !== 16'h0030) begin
      errors++;
      $display("FAIL b2b_restart: got busy=%0b en=%0b addr=%h, required 1 1 0030", busy, isram_en, isram_addr);
    end
    run_until_done(20, "b2b");
    checks++;
    if (exp_q.size() != 0 || bad_fetch != 0) begin
      errors++;
      $display("FAIL b2b_stream: got %0d left, %0d bad reads, required 0 0", exp_q.size(), bad_fetch);
    end
    repeat (2) cycle();
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) sram[a] = {5'b00101, 11'(a)};
    sram[16'h0010] = 16'h0800;
    sram[16'h0011] = 16'h1801;
    sram[16'h0012] = 16'h0000;
    sram[16'h0013] = 16'hF800;
    for (int i = 0; i < 9; i++) sram[16'h0020 + i] = {5'(i + 1), 11'(i * 3)};
    sram[16'h0029] = 16'hF829;
    sram[16'h0030] = 16'h0001;
    sram[16'h0031] = 16'hF800;

    test_reset();
    test_straight();
    test_backpressure();
    test_redirect();
    test_redirect_drain();
    test_wrap();
    test_reset_mid();
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
